// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 window generator: state encoding,
// window tap indices and small padding helpers.
package median_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned WIN_TAPS   = 9;

    // Tap index k = 3*dr + dc, row-major from top-left
    localparam logic [3:0] WIN_TL     = 4'd0;
    localparam logic [3:0] WIN_TC     = 4'd1;
    localparam logic [3:0] WIN_TR     = 4'd2;
    localparam logic [3:0] WIN_ML     = 4'd3;
    localparam logic [3:0] WIN_CENTRE = 4'd4;
    localparam logic [3:0] WIN_MR     = 4'd5;
    localparam logic [3:0] WIN_BL     = 4'd6;
    localparam logic [3:0] WIN_BC     = 4'd7;
    localparam logic [3:0] WIN_BR     = 4'd8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } win_state_t;

    function automatic logic [3:0] tap_idx(input logic [1:0] dr, input logic [1:0] dc);
        return 4'(3 * dr) + 4'(dc);
    endfunction

    // True when offset d (0 = before, 2 = after) falls outside the image
    function automatic logic pad_hit(input logic [1:0] d, input logic lo_out, input logic hi_out);
        return ((d == 2'd0) && lo_out) || ((d == 2'd2) && hi_out);
    endfunction

    // Offset to read instead when replicating the nearest in-image pixel
    function automatic logic [1:0] pad_src(input logic [1:0] d, input logic lo_out, input logic hi_out);
        if (pad_hit(d, lo_out, hi_out)) begin
            return 2'd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line pixel delay: single write port, single asynchronous read port.
module line_buffer #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 640,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents need no reset: stale data only ever lands in padded taps
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/window_3x3.sv
// Streaming 3x3 neighbourhood generator over a raster-order frame.
// Define WIN_REPLICATE_EN for edge replication; default pads with zero.
module window_3x3
    import median_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     pixel_i,
    output logic                  valid_o,
    output logic [9*DATA_W-1:0]   window_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned FL_W  = $clog2(IMG_WIDTH + 1);

    win_state_t        state;
    logic [COL_W-1:0]  in_col;
    logic [ROW_W-1:0]  in_row;
    logic [COL_W-1:0]  out_col;
    logic [ROW_W-1:0]  out_row;
    logic [FL_W-1:0]   fl_cnt;
    logic [DATA_W-1:0] raw  [WIN_TAPS];
    logic [DATA_W-1:0] nraw [WIN_TAPS];
    logic [9*DATA_W-1:0] nwin;

    logic              accept_c;
    logic              emit_c;
    logic              in_last_c;
    logic [DATA_W-1:0] pix_c;
    logic [DATA_W-1:0] lb0_q;
    logic [DATA_W-1:0] lb1_q;
    logic              top_out;
    logic              bot_out;
    logic              lft_out;
    logic              rgt_out;

    // During flush the stream is fed internal zeros and the input is ignored
    assign accept_c  = (state == ST_FLUSH) || valid_i;
    assign emit_c    = accept_c && (state != ST_FILL);
    assign pix_c     = (state == ST_FLUSH) ? '0 : pixel_i;
    assign in_last_c = (in_row == ROW_W'(IMG_HEIGHT - 1)) && (in_col == COL_W'(IMG_WIDTH - 1));

    assign top_out = (out_row == '0);
    assign bot_out = (out_row == ROW_W'(IMG_HEIGHT - 1));
    assign lft_out = (out_col == '0);
    assign rgt_out = (out_col == COL_W'(IMG_WIDTH - 1));

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept_c),
        .waddr (in_col),
        .wdata (pix_c),
        .raddr (in_col),
        .rdata (lb0_q)
    );

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept_c),
        .waddr (in_col),
        .wdata (lb0_q),
        .raddr (in_col),
        .rdata (lb1_q)
    );

    // Shift the 3x3 register left by one column and append the new column
    always_comb begin
        nraw         = raw;
        nraw[WIN_TL] = raw[WIN_TC];
        nraw[WIN_TC] = raw[WIN_TR];
        nraw[WIN_TR] = lb1_q;
        nraw[WIN_ML] = raw[WIN_CENTRE];
        nraw[WIN_CENTRE] = raw[WIN_MR];
        nraw[WIN_MR] = lb0_q;
        nraw[WIN_BL] = raw[WIN_BC];
        nraw[WIN_BC] = raw[WIN_BR];
        nraw[WIN_BR] = pix_c;
    end

    // Substitute out-of-image taps according to the centre position
    always_comb begin
        nwin = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
`ifdef WIN_REPLICATE_EN
                nwin[(3*dr+dc)*DATA_W +: DATA_W] =
                    nraw[tap_idx(pad_src(2'(dr), top_out, bot_out),
                                 pad_src(2'(dc), lft_out, rgt_out))];
`else
                nwin[(3*dr+dc)*DATA_W +: DATA_W] =
                    (pad_hit(2'(dr), top_out, bot_out) || pad_hit(2'(dc), lft_out, rgt_out))
                    ? '0 : nraw[tap_idx(2'(dr), 2'(dc))];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FILL;
            in_col   <= '0;
            in_row   <= '0;
            out_col  <= '0;
            out_row  <= '0;
            fl_cnt   <= '0;
            raw      <= '{default: '0};
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            window_o <= '0;
        end else begin
            valid_o <= emit_c;
            done_o  <= emit_c && bot_out && rgt_out;

            if (accept_c) begin
                raw <= nraw;
                if (in_col == COL_W'(IMG_WIDTH - 1)) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end

            if (emit_c) begin
                window_o <= nwin;
                if (rgt_out) begin
                    out_col <= '0;
                    out_row <= bot_out ? '0 : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end

            // Later assignments below override the counter advance above
            case (state)
                ST_FILL: begin
                    busy_o <= 1'b0;
                    if (accept_c && (in_row == ROW_W'(1)) && (in_col == '0)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_c && in_last_c) begin
                        state  <= ST_FLUSH;
                        busy_o <= 1'b1;
                        fl_cnt <= '0;
                    end
                end
                ST_FLUSH: begin
                    fl_cnt <= fl_cnt + 1'b1;
                    if (fl_cnt == FL_W'(IMG_WIDTH)) begin
                        state  <= ST_FILL;
                        busy_o <= 1'b0;
                        in_col <= '0;
                        in_row <= '0;
                    end
                end
                default: begin
                    state  <= ST_FILL;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_3x3.sv
// Scoreboard bench for window_3x3 on a 4x4 frame of pixels 1..16.
// Expected windows follow the padding mode selected by WIN_REPLICATE_EN.
module tb_window_3x3;

    localparam int unsigned DW   = 8;
    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int          NPIX = 16;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              valid_i = 1'b0;
    logic [DW-1:0]     pixel_i = '0;
    logic              valid_o;
    logic [9*DW-1:0]   window_o;
    logic              busy_o;
    logic              done_o;

    window_3x3 #(
        .DATA_W     (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .pixel_i  (pixel_i),
        .valid_o  (valid_o),
        .window_o (window_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*DW-1:0] win;
        bit              done;
        int              cyc;
        int              idx;
    } exp_t;

    exp_t            q[$];
    exp_t            mon_e;
    logic [9*DW-1:0] exp_tab [NPIX];
    int              cyc         = 0;
    int              vectors     = 0;
    int              miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9*DW-1:0] mk(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        return {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int idx);
        exp_t e;
        e.win  = exp_tab[idx];
        e.done = (idx == NPIX - 1);
        e.cyc  = cyc;
        e.idx  = idx;
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept raster index n (pixel value n+1); its window is due next cycle
    task automatic send(input int n);
        valid_i = 1'b1;
        pixel_i = DW'(n + 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        pixel_i = 8'hEE;
        if (n >= int'(W) + 1) push(n - int'(W) - 1);
    endtask

    task automatic frame(input bit gaps, input bit junk);
        for (int n = 0; n < NPIX; n++) begin
            send(n);
            if (gaps && n < NPIX - 1) idle(1);
        end
        for (int s = 0; s <= int'(W); s++) begin
            check($sformatf("busy_flush_step%0d", s), 72'(busy_o), 72'(1));
            valid_i = junk;
            pixel_i = 8'd99;
            @(posedge clk);
            #1;
            push(NPIX - int'(W) - 1 + s);
        end
        valid_i = 1'b0;
        pixel_i = 8'hEE;
        check("busy_at_done", 72'(busy_o), 72'(0));
    endtask

    task automatic check_reset_state();
        check("rst_valid_o", 72'(valid_o), 72'(0));
        check("rst_busy_o", 72'(busy_o), 72'(0));
        check("rst_done_o", 72'(done_o), 72'(0));
        check("rst_window_o", window_o, 72'(0));
    endtask

    // Monitor: pop and compare on every valid_o, flag missing or stray windows
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_window idx=%0d: valid_o absent at cycle %0d, required 1", q[0].idx, q[0].cyc);
            void'(q.pop_front());
        end
        if (valid_o) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: valid_o=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = q.pop_front();
                check($sformatf("window_idx%0d", mon_e.idx), window_o, mon_e.win);
                check($sformatf("done_idx%0d", mon_e.idx), 72'(done_o), 72'(mon_e.done));
            end
        end else if (done_o) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_done: done_o=1 without valid_o at cycle %0d, required 0", cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef WIN_REPLICATE_EN
        exp_tab[0]  = mk( 1,  1,  2,  1,  1,  2,  5,  5,  6);
        exp_tab[1]  = mk( 1,  2,  3,  1,  2,  3,  5,  6,  7);
        exp_tab[2]  = mk( 2,  3,  4,  2,  3,  4,  6,  7,  8);
        exp_tab[3]  = mk( 3,  4,  4,  3,  4,  4,  7,  8,  8);
        exp_tab[4]  = mk( 1,  1,  2,  5,  5,  6,  9,  9, 10);
        exp_tab[5]  = mk( 1,  2,  3,  5,  6,  7,  9, 10, 11);
        exp_tab[6]  = mk( 2,  3,  4,  6,  7,  8, 10, 11, 12);
        exp_tab[7]  = mk( 3,  4,  4,  7,  8,  8, 11, 12, 12);
        exp_tab[8]  = mk( 5,  5,  6,  9,  9, 10, 13, 13, 14);
        exp_tab[9]  = mk( 5,  6,  7,  9, 10, 11, 13, 14, 15);
        exp_tab[10] = mk( 6,  7,  8, 10, 11, 12, 14, 15, 16);
        exp_tab[11] = mk( 7,  8,  8, 11, 12, 12, 15, 16, 16);
        exp_tab[12] = mk( 9,  9, 10, 13, 13, 14, 13, 13, 14);
        exp_tab[13] = mk( 9, 10, 11, 13, 14, 15, 13, 14, 15);
        exp_tab[14] = mk(10, 11, 12, 14, 15, 16, 14, 15, 16);
        exp_tab[15] = mk(11, 12, 12, 15, 16, 16, 15, 16, 16);
`else
        exp_tab[0]  = mk( 0,  0,  0,  0,  1,  2,  0,  5,  6);
        exp_tab[1]  = mk( 0,  0,  0,  1,  2,  3,  5,  6,  7);
        exp_tab[2]  = mk( 0,  0,  0,  2,  3,  4,  6,  7,  8);
        exp_tab[3]  = mk( 0,  0,  0,  3,  4,  0,  7,  8,  0);
        exp_tab[4]  = mk( 0,  1,  2,  0,  5,  6,  0,  9, 10);
        exp_tab[5]  = mk( 1,  2,  3,  5,  6,  7,  9, 10, 11);
        exp_tab[6]  = mk( 2,  3,  4,  6,  7,  8, 10, 11, 12);
        exp_tab[7]  = mk( 3,  4,  0,  7,  8,  0, 11, 12,  0);
        exp_tab[8]  = mk( 0,  5,  6,  0,  9, 10,  0, 13, 14);
        exp_tab[9]  = mk( 5,  6,  7,  9, 10, 11, 13, 14, 15);
        exp_tab[10] = mk( 6,  7,  8, 10, 11, 12, 14, 15, 16);
        exp_tab[11] = mk( 7,  8,  0, 11, 12,  0, 15, 16,  0);
        exp_tab[12] = mk( 0,  9, 10,  0, 13, 14,  0,  0,  0);
        exp_tab[13] = mk( 9, 10, 11, 13, 14, 15,  0,  0,  0);
        exp_tab[14] = mk(10, 11, 12, 14, 15, 16,  0,  0,  0);
        exp_tab[15] = mk(11, 12,  0, 15, 16,  0,  0,  0,  0);
`endif
        rst_n = 1'b0;
        idle(2);
        check_reset_state();
        rst_n = 1'b1;
        idle(1);

        // Back-to-back frame
        frame(1'b0, 1'b0);
        idle(3);

        // valid_i toggling 1010...
        frame(1'b1, 1'b0);
        idle(3);

        // Abort after pixel 9, then a clean frame
        for (int n = 0; n < 9; n++) send(n);
        idle(1);
        check("queue_empty_before_reset", 72'(q.size()), 72'(0));
        rst_n = 1'b0;
        idle(1);
        check_reset_state();
        rst_n = 1'b1;
        idle(1);
        frame(1'b0, 1'b0);
        idle(3);

        // valid_i held high with junk during flush, next frame right after done_o
        frame(1'b0, 1'b1);
        frame(1'b0, 1'b0);
        idle(5);
        check("queue_empty_at_end", 72'(q.size()), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line (>=3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (>=3).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port valid_i  input  1  pixel_i valid this cycle.
REQ-007 SHALL have port pixel_i  input  DATA_W  raster-order input pixel.
REQ-008 SHALL have port valid_o  output  1  window_o valid this cycle.
REQ-009 SHALL have port window_o  output  9*DATA_W  3x3 window; slice k = 3*dr+dc (dr,dc in 0..2), k=0 top-left, k=4 centre, k=8 bottom-right.
REQ-010 SHALL have port busy_o  output  1  high while end-of-frame flush runs.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse with the frame's last window.

Function
REQ-012 SHALL accept one pixel per cycle with valid_i high; valid_i low holds all state and drives valid_o low the next cycle.
REQ-013 SHALL track input column/row counters wrapping at IMG_WIDTH-1 / IMG_HEIGHT-1.
REQ-014 SHALL store the previous two lines in two line buffers of depth IMG_WIDTH.
REQ-015 SHALL emit exactly IMG_WIDTH*IMG_HEIGHT windows per frame, one per centre pixel, in raster order.
REQ-016 SHALL emit the window for centre (r,c) one cycle after accepting raster index r*IMG_WIDTH+c+IMG_WIDTH+1.
REQ-017 SHALL replace out-of-image neighbours (r-1<0, r+1>=IMG_HEIGHT, c-1<0, c+1>=IMG_WIDTH) with zero.
REQ-018 SHALL, after the frame's last pixel, enter FLUSH: busy_o high, IMG_WIDTH+1 internal zero pixels generated one per cycle, producing the remaining windows.
REQ-019 SHALL ignore valid_i while busy_o is high.
REQ-020 SHALL assert done_o coincident with valid_o of centre (IMG_HEIGHT-1, IMG_WIDTH-1), then return to IDLE/FILL ready for the next frame the following cycle.
REQ-021 SHALL implement states FILL (first IMG_WIDTH+1 pixels, no output), RUN (one window per accepted pixel), FLUSH; FILL->RUN on pixel IMG_WIDTH+1, RUN->FLUSH on last pixel, FLUSH->FILL after last flush step.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear counters, state (to FILL), valid_o, busy_o, done_o and window_o to zero.
REQ-023 SHALL not require line buffer contents to be cleared; padding masking guarantees correctness.
REQ-024 SHALL, on reset mid-frame, discard the partial frame; the next accepted pixel is (0,0).

Configuration
REQ-025 SHALL, with WIN_REPLICATE_EN defined, replace out-of-image neighbours with the nearest in-image pixel (edge replication) instead of zero.
REQ-026 SHALL, without WIN_REPLICATE_EN, use zero padding per REQ-017; latency and counts identical in both modes.

Structure
REQ-027 SHALL take DATA_W defaults, window index constants (WIN_TL..WIN_BR, WIN_CENTRE=4) and the state enum from shared package median_pkg.
REQ-028 SHALL instantiate sub-module line_buffer (single-write, single-read, depth IMG_WIDTH, DATA_W wide) twice.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixels 1..16 back-to-back)
REQ-029 SHALL check: first valid_o one cycle after pixel 6 accepted, window_o = {0,0,0,0,1,2,0,5,6} (k=0..8).
REQ-030 SHALL check: centre (1,1) window = {1,2,3,5,6,7,9,10,11}; centre (3,3) window = {11,12,0,15,16,0,0,0,0} with done_o high, busy_o high for 5 cycles before it, 16 valid_o total.
REQ-031 SHALL check: valid_i toggled 1010... over the frame -> identical 16 windows, valid_o gaps match input gaps.
REQ-032 SHALL check: rst_n pulsed low after pixel 9, then pixels 1..16 -> outputs identical to REQ-029/030, none from the aborted frame.
REQ-033 SHALL check: valid_i held high during FLUSH with pixel 99 -> ignored, windows unchanged; second frame immediately after done_o correct.
REQ-034 SHALL check with WIN_REPLICATE_EN: centre (0,0) window = {1,1,2,1,1,2,5,5,6}; centre (3,3) = {11,12,12,15,16,16,15,16,16}.
